// File: rtl/stego_extract.sv
// LSB steganography recovery: packs eight byte LSBs MSB-first into a character,
// XORs it with a repeating key from internal RAM and streams it out until msg_len chars.
module stego_extract #(
  parameter int KEY_LEN = 104,
  parameter int CNT_W   = 11,
  parameter int KA_W    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] msg_len,
  input  logic             key_we,
  input  logic [KA_W-1:0]  key_addr,
  input  logic [7:0]       key_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_data,
  output logic             chr_valid,
  input  logic             chr_ready,
  output logic [7:0]       chr_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, EXTRACT, FLUSH, DONE} state_t;

  state_t           state_q;
  logic [2:0]       bit_cnt_q;
  logic [CNT_W-1:0] char_cnt_q;
  logic [CNT_W-1:0] msg_len_q;
  logic [KA_W-1:0]  key_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       chr_data_q;
  logic             chr_valid_q;
  logic             busy_q;
  logic             done_q;

  logic [7:0]       key_mem [KEY_LEN];

  logic             chr_fire;
  logic             pix_rdy_d;
  logic             pix_fire;
  logic             char_done;
  logic             key_wr;
  logic [7:0]       shift_d;
  logic [CNT_W-1:0] char_cnt_d;
  logic [KA_W-1:0]  key_idx_d;

  always_comb begin
    chr_fire   = chr_valid_q && chr_ready;
    // Only the byte that would complete a character waits for the output slot.
    pix_rdy_d  = (state_q == EXTRACT) &&
                 !(bit_cnt_q == 3'd7 && chr_valid_q && !chr_ready);
    pix_fire   = pix_valid && pix_rdy_d;
    char_done  = pix_fire && (bit_cnt_q == 3'd7);
    shift_d    = {shift_q[6:0], pix_data[0]};
    char_cnt_d = char_cnt_q + CNT_W'(1);
    key_idx_d  = (key_idx_q == KA_W'(KEY_LEN - 1)) ? '0 : key_idx_q + KA_W'(1);
    key_wr     = key_we && !busy_q && ({1'b0, key_addr} < (KA_W + 1)'(KEY_LEN));
  end

  // Key RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (key_wr) key_mem[key_addr] <= key_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      char_cnt_q  <= '0;
      msg_len_q   <= '0;
      key_idx_q   <= '0;
      shift_q     <= '0;
      chr_data_q  <= '0;
      chr_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (chr_fire) chr_valid_q <= 1'b0;
      if (pix_fire) begin
        shift_q   <= shift_d;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (char_done) begin
        chr_data_q  <= shift_d ^ key_mem[key_idx_q];
        chr_valid_q <= 1'b1;
        key_idx_q   <= key_idx_d;
        char_cnt_q  <= char_cnt_d;
        if (char_cnt_d == msg_len_q) state_q <= FLUSH;
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            msg_len_q  <= msg_len;
            bit_cnt_q  <= '0;
            char_cnt_q <= '0;
            key_idx_q  <= '0;
            if (msg_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= EXTRACT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (chr_fire) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_ready = pix_rdy_d;
  assign chr_valid = chr_valid_q;
  assign chr_data  = chr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/stego_extract.md
# stego_extract

Downstream recovery stage for the LSB steganography path. It consumes the stego image as a stream of 8-bit colour-channel bytes and takes the LSB of each byte. It packs eight LSBs, MSB first, into one character and XOR-decrypts it with a repeating key held in an internal key RAM. Plaintext characters are emitted on a valid/ready stream until a programmed message length is reached.

## Interface
Parameters:
- KEY_LEN, 104, number of key bytes; key index wraps modulo KEY_LEN.
- CNT_W, 11, width of the message-length and character counters.
- KA_W, 7, key address width; must satisfy 2^KA_W >= KEY_LEN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; begins extraction. Honoured only in IDLE or DONE.
- msg_len  in  CNT_W  number of characters to recover; sampled on an accepted start.
- key_we  in  1  key RAM write strobe.
- key_addr  in  KA_W  key RAM write address.
- key_data  in  8  key byte to write.
- pix_valid  in  1  upstream byte valid.
- pix_ready  out  1  this block accepts pix_data.
- pix_data  in  8  stego channel byte; only bit 0 is used.
- chr_valid  out  1  decrypted character available.
- chr_ready  in  1  downstream accepts chr_data.
- chr_data  out  8  decrypted character.
- busy  out  1  high in EXTRACT and FLUSH.
- done  out  1  message complete; held until the next start or reset.

## Operation
- States:
  - IDLE: entered on reset.
  - EXTRACT: collecting bits.
  - FLUSH: last character waiting for handshake.
  - DONE: message complete.
- Reset values: state IDLE; pix_ready, chr_valid, busy and done are 0; chr_data is 0x00. bit_cnt, char_cnt, key_idx and the shift register are 0. Key RAM contents are not reset.
- Key RAM:
  - A write occurs on key_we only when busy=0 and key_addr < KEY_LEN.
  - A write with busy=1 or key_addr >= KEY_LEN is ignored.
- IDLE/DONE + start:
  - Latch msg_len.
  - Clear bit_cnt, char_cnt and key_idx, and clear done.
  - If msg_len == 0, go to DONE (done=1 the following cycle).
  - Otherwise go to EXTRACT.
- Accepted byte (pix_valid && pix_ready):
  - shift <= {shift[6:0], pix_data[0]}.
  - bit_cnt increments modulo 8.
- On the 8th bit (bit_cnt == 7 at accept):
  - chr_data <= {shift[6:0], pix_data[0]} ^ key[key_idx]; chr_valid <= 1.
  - key_idx <= (key_idx == KEY_LEN-1) ? 0 : key_idx+1.
  - char_cnt increments. If the new char_cnt equals msg_len, go to FLUSH.
- pix_ready = (state == EXTRACT) && !(bit_cnt == 7 && chr_valid && !chr_ready). The stall applies only to the completing byte, so earlier bits keep flowing during backpressure.
- chr_valid clears on a chr_ready handshake, unless a new character loads in the same cycle. In that case chr_valid stays 1 and chr_data takes the new value.
- FLUSH:
  - pix_ready = 0.
  - On chr_valid && chr_ready, go to DONE with done=1 and busy=0.
- DONE: pix_ready = 0. Extra upstream bytes are not consumed.
- start while busy is ignored. Reset in any state aborts immediately and discards any partial character; key RAM is retained.

## Timing
- chr_data and chr_valid are registered. A character is visible the cycle after its 8th byte is accepted.
- Peak throughput is one byte per cycle, i.e. one character per 8 cycles. There are no bubbles while chr_ready=1.
- busy rises the cycle after an accepted start with msg_len != 0.
- done rises the cycle after the final chr handshake. For msg_len=0, done rises the cycle after start.
- chr_data holds stable while chr_valid=1 and chr_ready=0.

## Test plan
- Decode one character: key[0]=0x00, msg_len=1, eight bytes with LSBs 0,1,0,0,0,0,0,1 and chr_ready=1 -> chr_data=0x41 with chr_valid the cycle after the 8th accept; done=1 one cycle after the handshake; pix_ready=0 afterwards.
- Decrypt: key[0]=0x20 with the same stimulus -> chr_data=0x61.
- Key wrap (KEY_LEN=2): keys 0x01,0x02; msg_len=3; each character's bits encode 0x40 -> outputs 0x41, 0x42, 0x41.
- Backpressure: msg_len=2, chr_ready=0 after the first character -> pix_ready drops at bit_cnt=7 of the second character. Release chr_ready -> 0x41 consumed, the second character appears the next cycle, and no byte is lost or duplicated.
- Zero length: start with msg_len=0 -> done=1 the next cycle, pix_ready never high, chr_valid never high.
- Reset mid-message: reset after 3 accepted bytes, then restart with msg_len=1 and 8 new bytes -> the character is built only from the new bytes. Key written before the reset is still applied. A key_we issued while busy leaves the key unchanged.
